// File: rtl/token_lexer_pkg.sv
// Shared constants for the token lexer: token tags, special characters,
// FSM state encoding and small character-class helpers.
package token_lexer_pkg;

  localparam logic [7:0] TAG_NUM    = 8'h00;
  localparam logic [7:0] TAG_PLUS   = 8'h01;
  localparam logic [7:0] TAG_MINUS  = 8'h02;
  localparam logic [7:0] TAG_SEMI   = 8'h03;
  localparam logic [7:0] TAG_MUL    = 8'h04;
  localparam logic [7:0] TAG_DIV    = 8'h05;
  localparam logic [7:0] TAG_LPAREN = 8'h06;
  localparam logic [7:0] TAG_RPAREN = 8'h07;
  localparam logic [7:0] TAG_ASSIGN = 8'h08;
  localparam logic [7:0] TAG_EQ     = 8'h09;
  localparam logic [7:0] TAG_ERR    = 8'hFE;
  localparam logic [7:0] TAG_EOF    = 8'hFF;

  localparam logic [7:0] CH_TAB = 8'h09;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_NUL = 8'h00;
  localparam logic [7:0] CH_DEL = 8'hFF;
  localparam logic [7:0] CH_EQ  = 8'h3D;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NUM  = 2'd1,
    ST_ASG  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic logic is_ws(input logic [7:0] c);
    return (c == CH_TAB) || (c == CH_LF) || (c == CH_CR) || (c == CH_SP);
  endfunction

  function automatic logic is_eof(input logic [7:0] c);
    return (c == CH_NUL) || (c == CH_DEL);
  endfunction

  // Returns {hit, tag} for the one-character operator tokens.
  function automatic logic [8:0] single_tag(input logic [7:0] c);
    case (c)
      8'h2B:   return {1'b1, TAG_PLUS};
      8'h2D:   return {1'b1, TAG_MINUS};
      8'h3B:   return {1'b1, TAG_SEMI};
      8'h2A:   return {1'b1, TAG_MUL};
      8'h2F:   return {1'b1, TAG_DIV};
      8'h28:   return {1'b1, TAG_LPAREN};
      8'h29:   return {1'b1, TAG_RPAREN};
      default: return 9'h000;
    endcase
  endfunction

endpackage

// File: rtl/token_lexer_if.sv
// Character-in / token-out handshake bundle for the token lexer.
interface token_lexer_if #(
  parameter int NUM_W = 16
);
  logic             i_valid;
  logic [7:0]       i_data;
  logic             i_ready;
  logic             o_valid;
  logic             o_ready;
  logic [7:0]       o_tag;
  logic [NUM_W-1:0] o_data;

  modport master (
    output i_valid, i_data, o_ready,
    input  i_ready, o_valid, o_tag, o_data
  );

  modport slave (
    input  i_valid, i_data, o_ready,
    output i_ready, o_valid, o_tag, o_data
  );
endinterface

// File: rtl/token_fifo.sv
// First-word-fall-through token FIFO; read data is forced to zero while empty.
module token_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_FULL);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && !o_full;
  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/token_lexer.sv
// Character-stream lexer: turns ASCII bytes into (tag, value) tokens and
// buffers them in a first-word-fall-through FIFO.
module token_lexer
  import token_lexer_pkg::*;
#(
  parameter int NUM_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  token_lexer_if.slave bus
);
  localparam int ACC_W = NUM_W + 4;
  localparam logic [ACC_W-1:0] ACC_MAX = {4'b0000, {NUM_W{1'b1}}};

  state_t             r_state;
  logic [NUM_W-1:0]   r_acc;
  logic               r_ovf;
  logic [7:0]         r_hold;
  logic               r_run;

  state_t             w_state_next;
  logic [NUM_W-1:0]   w_acc_next;
  logic               w_ovf_next;
  logic [7:0]         w_hold_next;
  logic               w_push;
  logic [7:0]         w_tag;
  logic [NUM_W-1:0]   w_data;
  logic               w_full;
  logic               w_empty;
  logic               w_go;
  logic               w_i_ready;
  logic [7:0]         w_char;
  logic [8:0]         w_single;
  logic [ACC_W-1:0]   w_mul;
  logic [8+NUM_W-1:0] w_rdata;

  // r_run keeps the input closed until the first edge after reset release.
  assign w_i_ready = r_run && !w_full && (r_state != ST_HOLD);
  assign w_char    = (r_state == ST_HOLD) ? r_hold : bus.i_data;
  assign w_go      = (r_state == ST_HOLD) ? !w_full : (bus.i_valid && w_i_ready);
  assign w_single  = single_tag(w_char);
  assign w_mul     = ACC_W'(r_acc) * ACC_W'(10) + ACC_W'(w_char[3:0]);

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_ovf_next   = r_ovf;
    w_hold_next  = r_hold;
    w_push       = 1'b0;
    w_tag        = TAG_NUM;
    w_data       = '0;
    if (w_go) begin
      case (r_state)
        ST_NUM: begin
          if (is_digit(w_char)) begin
            if (w_mul > ACC_MAX) begin
              w_ovf_next = 1'b1;
              w_acc_next = '1;
            end else begin
              w_acc_next = w_mul[NUM_W-1:0];
            end
          end else begin
            w_push     = 1'b1;
            w_tag      = r_ovf ? TAG_ERR : TAG_NUM;
            w_data     = r_ovf ? '0 : r_acc;
            w_acc_next = '0;
            w_ovf_next = 1'b0;
            if (is_ws(w_char)) begin
              w_state_next = ST_IDLE;
            end else begin
              w_hold_next  = w_char;
              w_state_next = ST_HOLD;
            end
          end
        end
        ST_ASG: begin
          w_push = 1'b1;
          if (w_char == CH_EQ) begin
            w_tag        = TAG_EQ;
            w_state_next = ST_IDLE;
          end else begin
            w_tag        = TAG_ASSIGN;
            w_hold_next  = w_char;
            w_state_next = ST_HOLD;
          end
        end
        default: begin
          // IDLE and a released HOLD share the same character handling.
          w_state_next = ST_IDLE;
          if (is_digit(w_char)) begin
            w_acc_next   = NUM_W'(w_char[3:0]);
            w_state_next = ST_NUM;
          end else if (w_char == CH_EQ) begin
            w_state_next = ST_ASG;
          end else if (w_single[8]) begin
            w_push = 1'b1;
            w_tag  = w_single[7:0];
          end else if (is_eof(w_char)) begin
            w_push = 1'b1;
            w_tag  = TAG_EOF;
          end else if (!is_ws(w_char)) begin
            w_push = 1'b1;
            w_tag  = TAG_ERR;
            w_data = NUM_W'(w_char);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_hold  <= '0;
      r_run   <= 1'b0;
    end else begin
      r_run   <= 1'b1;
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_ovf   <= w_ovf_next;
      r_hold  <= w_hold_next;
    end
  end

  token_fifo #(
    .WIDTH (8 + NUM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata ({w_tag, w_data}),
    .i_pop   (bus.o_ready),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.i_ready = w_i_ready;
  assign bus.o_valid = !w_empty;
  assign bus.o_tag   = w_rdata[8+NUM_W-1 -: 8];
  assign bus.o_data  = w_rdata[NUM_W-1:0];
endmodule

// File: tb/tb_token_lexer.sv
// Self-checking bench for token_lexer: directed streams plus random streams
// checked against a string-level tokenizer model.
module tb_token_lexer;
  localparam int NUM_W      = 8;
  localparam int FIFO_DEPTH = 4;
  localparam longint MAXV   = (longint'(1) << NUM_W) - 1;

  typedef struct {
    logic [7:0]       tag;
    logic [NUM_W-1:0] data;
  } tok_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  bit   drv_done = 1'b0;

  byte unsigned stim_q[$];
  tok_t         exp_q[$];
  string        ops = "+-;*/()";
  byte unsigned ws_tab [4] = '{8'h09, 8'h0A, 8'h0D, 8'h20};

  token_lexer_if #(.NUM_W(NUM_W)) bus();

  token_lexer #(.NUM_W(NUM_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic fail_timeout(input string tag);
    checks++;
    failures++;
    $error("FAIL %s timeout got=none exp=progress", tag);
  endtask

  task automatic ex(input logic [7:0] t, input logic [NUM_W-1:0] d);
    tok_t x;
    x.tag  = t;
    x.data = d;
    exp_q.push_back(x);
  endtask

  task automatic push_str(input string s);
    for (int k = 0; k < s.len(); k++) stim_q.push_back(s[k]);
  endtask

  // Tokenizes the whole stimulus string; a trailing unterminated number or '=' stays pending.
  task automatic model();
    int           i;
    int           j;
    int           tag;
    byte unsigned c;
    longint       v;
    bit           ovf;
    i = 0;
    while (i < stim_q.size()) begin
      c = stim_q[i];
      if (c >= 8'h30 && c <= 8'h39) begin
        v = 0;
        ovf = 1'b0;
        j = i;
        while (j < stim_q.size() && stim_q[j] >= 8'h30 && stim_q[j] <= 8'h39) begin
          v = v * 10 + (longint'(stim_q[j]) - 48);
          if (v > MAXV) begin
            v = MAXV;
            ovf = 1'b1;
          end
          j++;
        end
        if (j >= stim_q.size()) break;
        if (ovf) ex(8'hFE, '0);
        else     ex(8'h00, NUM_W'(v));
        i = j;
      end else if (c == 8'h3D) begin
        if (i + 1 >= stim_q.size()) break;
        if (stim_q[i+1] == 8'h3D) begin
          ex(8'h09, '0);
          i += 2;
        end else begin
          ex(8'h08, '0);
          i += 1;
        end
      end else begin
        tag = -1;
        for (int k = 0; k < ops.len(); k++) if (c == ops[k]) tag = k + 1;
        if (tag > 0)                                      ex(8'(tag), '0);
        else if (c == 8'h00 || c == 8'hFF)                ex(8'hFF, '0);
        else if (!(c == 9 || c == 10 || c == 13 || c == 32)) ex(8'hFE, NUM_W'(c));
        i += 1;
      end
    end
  endtask

  task automatic gen_random();
    int           n;
    int           r;
    byte unsigned c;
    n = $urandom_range(8, 24);
    for (int k = 0; k < n; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 40)      c = 8'(48 + $urandom_range(0, 9));
      else if (r < 60) c = ops[$urandom_range(0, 6)];
      else if (r < 70) c = 8'h3D;
      else if (r < 82) c = ws_tab[$urandom_range(0, 3)];
      else if (r < 87) c = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
      else if (r < 97) c = 8'(97 + $urandom_range(0, 25));
      else             c = 8'h23;
      stim_q.push_back(c);
    end
    stim_q.push_back(8'h20);
  endtask

  task automatic send_char(input byte unsigned c);
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      bus.i_valid = 1'b1;
      bus.i_data  = c;
      if (bus.i_ready === 1'b1) begin
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        return;
      end
      t++;
      if (t > 500) begin
        bus.i_valid = 1'b0;
        fail_timeout("send_char");
        return;
      end
    end
  endtask

  // Drives stim_q and collects tokens against exp_q; o_ready is held low for the first 'stall' cycles.
  task automatic run_stream(input int pct, input int stall);
    int               got;
    int               cyc;
    bit               stalled;
    bit               done;
    bit               extra;
    logic [7:0]       ptag;
    logic [NUM_W-1:0] pdata;
    got = 0; cyc = 0; stalled = 1'b0; done = 1'b0; extra = 1'b0;
    ptag = '0; pdata = '0;
    drv_done = 1'b0;
    fork
      begin
        foreach (stim_q[k]) send_char(stim_q[k]);
        drv_done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          if (stalled) begin
            chk("hold_valid", 32'(bus.o_valid), 32'd1);
            chk("hold_tag", 32'(bus.o_tag), 32'(ptag));
            chk("hold_data", 32'(bus.o_data), 32'(pdata));
          end
          if (stall > 0 && cyc == stall) begin
            chk("full_i_ready", 32'(bus.i_ready), 32'd0);
            chk("full_o_valid", 32'(bus.o_valid), 32'd1);
          end
          bus.o_ready = (cyc < stall) ? 1'b0 : (int'($urandom_range(0, 99)) < pct);
          if (bus.o_valid === 1'b1 && bus.o_ready) begin
            if (got < exp_q.size()) begin
              chk($sformatf("tok%0d_tag", got), 32'(bus.o_tag), 32'(exp_q[got].tag));
              chk($sformatf("tok%0d_data", got), 32'(bus.o_data), 32'(exp_q[got].data));
              $display("token %0d tag=%02h data=%0d", got, bus.o_tag, bus.o_data);
            end else begin
              checks++;
              failures++;
              $error("FAIL extra_token got tag=0x%0h data=0x%0h exp=none", bus.o_tag, bus.o_data);
            end
            got++;
          end
          stalled = (bus.o_valid === 1'b1) && !bus.o_ready;
          ptag    = bus.o_tag;
          pdata   = bus.o_data;
          cyc++;
          if (drv_done && got >= exp_q.size()) done = 1'b1;
          else if (cyc > 4000) begin
            fail_timeout("collect");
            done = 1'b1;
          end
        end
      end
    join
    bus.o_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus.o_valid === 1'b1) extra = 1'b1;
    end
    chk("no_extra_tokens", 32'(extra), 32'd0);
    chk("idle_i_ready", 32'(bus.i_ready), 32'd1);
    bus.o_ready = 1'b0;
    stim_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_o_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_o_tag", 32'(bus.o_tag), 32'd0);
    chk("rst_o_data", 32'(bus.o_data), 32'd0);
    chk("rst_i_ready", 32'(bus.i_ready), 32'd0);
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("release_i_ready", 32'(bus.i_ready), 32'd0);
    @(posedge clk);
    #1 chk("first_edge_i_ready", 32'(bus.i_ready), 32'd1);
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_data  = 8'h00;
    bus.o_ready = 1'b0;
    do_reset();

    // Operators delimit numbers; trailing NUL is EOF.
    push_str("12+3;");
    stim_q.push_back(8'h00);
    ex(8'h00, 8'd12); ex(8'h01, '0); ex(8'h00, 8'd3); ex(8'h03, '0); ex(8'hFF, '0);
    run_stream(100, 0);

    // Unknown characters, '==' versus '=' and EOF straight after a number.
    push_str("a==b=1");
    stim_q.push_back(8'h00);
    ex(8'hFE, 8'h61); ex(8'h09, '0); ex(8'hFE, 8'h62); ex(8'h08, '0); ex(8'h00, 8'd1); ex(8'hFF, '0);
    run_stream(100, 0);

    // Largest representable value, then saturation into ERR.
    push_str("255 256 ");
    ex(8'h00, 8'd255); ex(8'hFE, '0);
    run_stream(60, 0);

    // Sink stalled: input must stop once four tokens are buffered.
    push_str("1+2+3+");
    ex(8'h00, 8'd1); ex(8'h01, '0); ex(8'h00, 8'd2); ex(8'h01, '0); ex(8'h00, 8'd3); ex(8'h01, '0);
    run_stream(100, 20);

    // Simultaneous push and pop at occupancy three.
    bus.o_ready = 1'b0;
    send_char(8'h31); send_char(8'h2B); send_char(8'h2B);
    @(negedge clk);
    chk("occ3_i_ready", 32'(bus.i_ready), 32'd1);
    chk("occ3_head", 32'(bus.o_tag), 32'h00);
    bus.i_valid = 1'b1;
    bus.i_data  = 8'h3B;
    bus.o_ready = 1'b1;
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
    bus.o_ready = 1'b0;
    @(negedge clk);
    chk("pushpop_i_ready", 32'(bus.i_ready), 32'd1);
    chk("pushpop_head", 32'(bus.o_tag), 32'h01);
    send_char(8'h2D);
    @(negedge clk);
    chk("occ4_i_ready", 32'(bus.i_ready), 32'd0);
    ex(8'h01, '0); ex(8'h01, '0); ex(8'h03, '0); ex(8'h02, '0);
    run_stream(100, 0);

    // Reset with buffered tokens and a partial number pending.
    bus.o_ready = 1'b0;
    send_char(8'h39); send_char(8'h3B); send_char(8'h34); send_char(8'h35);
    do_reset();
    push_str("7 ");
    ex(8'h00, 8'd7);
    run_stream(100, 0);

    for (int it = 0; it < 25; it++) begin
      gen_random();
      model();
      run_stream(int'($urandom_range(30, 100)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/token_lexer.md
TOKEN_LEXER -- requirements
Module: token_lexer

Interface
REQ-001 Parameter NUM_W, default 16, width of numeric literal value (8..32).
REQ-002 Parameter FIFO_DEPTH, default 4, output token FIFO entries, power of two, at least 2.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 I_VALID  input  1  I_DATA holds a character.
REQ-006 I_DATA  input  8  ASCII character.
REQ-007 I_READY  output  1  lexer accepts I_DATA this cycle; a character is consumed only when I_VALID and I_READY are both high.
REQ-008 O_VALID  output  1  a token is presented.
REQ-009 O_READY  input  1  sink accepts the token; a token pops when O_VALID and O_READY are both high.
REQ-010 O_TAG  output  8  token tag.
REQ-011 O_DATA  output  NUM_W  token payload.

Function
REQ-012 Tags SHALL be: NUM 0x00, PLUS 0x01, MINUS 0x02, SEMICOLON 0x03, MUL 0x04, DIV 0x05, LPAREN 0x06, RPAREN 0x07, ASSIGN 0x08, EQ 0x09, ERR 0xFE, EOF 0xFF.
REQ-013 Whitespace SHALL be 0x09, 0x0A, 0x0D and 0x20; EOF characters SHALL be 0x00 and 0xFF.
REQ-014 Single-character tokens SHALL be '+', '-', ';', '*', '/', '(' and ')', with O_DATA = 0.
REQ-015 The FSM SHALL have the states IDLE, NUM, ASG and HOLD.
REQ-016 IDLE: a digit loads acc = digit and goes to NUM; '=' goes to ASG; a single-character token is pushed; whitespace is dropped; EOF pushes EOF; any other character pushes ERR with O_DATA = the character zero-extended.
REQ-017 NUM: a digit updates acc = acc*10 + digit in NUM_W+4 bits; a result above 2^NUM_W-1 sets a sticky ovf flag and keeps acc saturated.
REQ-018 NUM: a non-digit pushes NUM with acc, or ERR with O_DATA = 0 if ovf is set, then clears acc and ovf.
REQ-019 NUM: after the push in REQ-018, whitespace returns to IDLE; any other non-digit is latched into a hold register and goes to HOLD.
REQ-020 ASG: '=' pushes EQ and returns to IDLE; any other character pushes ASSIGN and is latched, then goes to HOLD.
REQ-021 HOLD: I_READY is low; when the FIFO is not full, the held character is processed exactly as in IDLE.
REQ-022 Numbers are delimited by operators as well as whitespace, so "12+3" yields NUM 12, PLUS, NUM 3.
REQ-023 EOF in NUM or ASG SHALL push the pending token and then push EOF on the following cycle via HOLD.
REQ-024 At most one FIFO push SHALL occur per cycle.
REQ-025 I_READY = !fifo_full && state != HOLD.
REQ-026 A pushed token is visible on O_VALID/O_TAG/O_DATA on the cycle after the push edge; with an empty FIFO, latency from the consuming edge is 1 cycle.
REQ-027 O_TAG/O_DATA SHALL hold stable while O_VALID is high and O_READY is low.
REQ-028 A push and a pop in the same cycle SHALL leave the occupancy unchanged.
REQ-029 A pop from an empty FIFO is ignored.
REQ-030 The FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 When the FIFO is full, input stalls and no token or character is lost or duplicated.

Reset
REQ-032 RST high SHALL asynchronously force O_VALID=0, O_TAG=0, O_DATA=0, I_READY=0, state IDLE, acc=0, ovf=0, hold register 0 and FIFO empty.
REQ-033 I_READY rises on the first clock edge after RST deasserts.
REQ-034 Reset mid-token SHALL discard partial tokens and FIFO contents, and no token is emitted for them.

Structure
REQ-035 Package token_lexer_pkg SHALL hold the tag constants, the FSM state encoding, and the whitespace and EOF character constants.
REQ-036 Sub-module token_fifo (parameters WIDTH, DEPTH; first-word-fall-through; full/empty outputs) SHALL hold the output tokens with WIDTH = 8+NUM_W.

Verification
REQ-037 Stream "12+3;" then 0x00 with O_READY=1 SHALL produce (00,12),(01,0),(00,3),(03,0),(FF,0) in order.
REQ-038 Stream "a==b=1" SHALL produce (FE,0x61),(09,0),(FE,0x62),(08,0),(00,1) before EOF.
REQ-039 With NUM_W=8, stream "255 256 " SHALL produce (00,255) then (FE,0).
REQ-040 With O_READY=0, stream "1+2+3+" SHALL drop I_READY after 4 tokens (FIFO_DEPTH=4); releasing O_READY then yields all 6 tokens in order with none lost.
REQ-041 Raising O_READY in the same cycle as a push while the FIFO holds 3 tokens SHALL keep occupancy at 3, and no full stall occurs.
REQ-042 Asserting RST after "45" (no delimiter) and then streaming "7 " SHALL produce only (00,7).
